// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-bank widths, requester IDs and write-arbiter state encoding
package cpu_pkg;
  localparam int REGF_ADDR_W = 4;
  localparam int REGF_DATA_W = 16;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} regarb_state_t;
endpackage

// File: rtl/wr_fifo2.sv
// wr_fifo2: two-entry synchronous FIFO; caller never pushes when full or pops when empty
module wr_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q, cnt_d;
  assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  // pointers and occupancy; stale entries need no reset since empty gates them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= !wr_q;
      if (pop_i) rd_q <= !rd_q;
      cnt_q <= cnt_d;
    end
  end
  // entry storage
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the bank write port between A and B, with drain-then-clear sequencing
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = REGF_ADDR_W,
  parameter int DATA_W = REGF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address_w,
  output logic [DATA_W-1:0] data_in_w,
  output logic              clear
);
  localparam int EW = ADDR_W + DATA_W;
  regarb_state_t     state_q, state_d;
  logic              prio_q, prio_d;
  logic              we_q, clear_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              a_full, a_empty, b_full, b_empty;
  logic [EW-1:0]     a_dout, b_dout, win_entry;
  logic              win, grant;
  assign a_ready    = state_q == RUN && !a_full;
  assign b_ready    = state_q == RUN && !b_full;
  assign grant      = state_q != CLEAR && !(a_empty && b_empty);
  assign win        = a_empty ? REQ_B : b_empty ? REQ_A : prio_q;
  assign win_entry  = win == REQ_B ? b_dout : a_dout;
  assign prio_d     = grant ? !win : prio_q;
  assign clear_busy = state_q != RUN;
  assign write_enable = we_q;
  assign address_w  = addr_q;
  assign data_in_w  = data_q;
  assign clear      = clear_q;
  wr_fifo2 #(.W(EW)) u_fifo_a (
    .clk(clk), .reset(reset), .push_i(a_valid && a_ready), .pop_i(grant && win == REQ_A),
    .din_i({a_addr, a_data}), .dout_o(a_dout), .full_o(a_full), .empty_o(a_empty)
  );
  wr_fifo2 #(.W(EW)) u_fifo_b (
    .clk(clk), .reset(reset), .push_i(b_valid && b_ready), .pop_i(grant && win == REQ_B),
    .din_i({b_addr, b_data}), .dout_o(b_dout), .full_o(b_full), .empty_o(b_empty)
  );
  // clear sequencing; DRAIN waits for the last write strobe to leave the output register
  always_comb begin
    state_d = state_q;
    state_d = (state_q == RUN && clear_req) ? DRAIN :
              (state_q == DRAIN && a_empty && b_empty && !we_q) ? CLEAR :
              (state_q == CLEAR) ? RUN : state_q;
  end
  // state, round-robin pointer and registered bank-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      prio_q  <= REQ_A;
      we_q    <= 1'b0;
      clear_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      we_q    <= grant;
      clear_q <= state_d == CLEAR;
      if (grant) {addr_q, data_q} <= win_entry;
    end
  end
endmodule
